clock_ctrl: RTL and testbench

Sequencing controller for the digital-clock datapath. It owns the 1 s time base and the run/set mode state machine, and drives per-digit count enables and clears into six cascaded BCD digit counters (seconds, minutes, hours; units and tens). It reads the counters' present digit values back to decide carries and the 23:59:59 → 00:00:00 wrap. The digit counters themselves stay outside this block.

---
 rtl/clock_pkg.sv | 26 ++
 rtl/key_edge.sv | 18 +
 rtl/clock_ctrl.sv | 133 +++++++++++++
 tb/tb_clock_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared mode encodings, BCD limits and pulse bundle for the clock datapath
package clock_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2
    } mode_t;

    localparam logic [3:0] UNITS_MAX      = 4'd9;
    localparam logic [3:0] TENS_MAX       = 4'd5;
    localparam logic [3:0] HOUR_TENS_MAX  = 4'd2;
    localparam logic [3:0] HOUR_UNITS_MAX = 4'd3;

    typedef struct packed {
        logic enSl;
        logic enSh;
        logic enMl;
        logic enMh;
        logic enHl;
        logic enHh;
        logic clrH;
        logic clrS;
    } pulse_t;

endpackage

// File: rtl/key_edge.sv
// rtl/key_edge.sv - rising-edge detector for a debounced, synchronous key level
module key_edge (
    input  logic CP,
    input  logic CR,
    input  logic key,
    output logic rise
);

    logic prev;

    // prev tracks the key even in reset, so a key held through reset never looks like a press
    always_ff @(posedge CP) begin
        prev <= key;
    end

    assign rise = key & ~prev & ~CR;

endmodule

// File: rtl/clock_ctrl.sv
// rtl/clock_ctrl.sv - time base, run/set mode FSM and digit enable/clear sequencing
module clock_ctrl
    import clock_pkg::*;
#(
    parameter int TICK_DIV = 1000
) (
    input  logic       CP,
    input  logic       CR,
    input  logic       KEY_MODE,
    input  logic       KEY_ADJ,
    input  logic [3:0] SL,
    input  logic [3:0] SH,
    input  logic [3:0] ML,
    input  logic [3:0] MH,
    input  logic [3:0] HL,
    input  logic [3:0] HH,
    output logic       EN_SL,
    output logic       EN_SH,
    output logic       EN_ML,
    output logic       EN_MH,
    output logic       EN_HL,
    output logic       EN_HH,
    output logic       CLR_H,
    output logic       CLR_S,
    output logic [1:0] MODE,
    output logic       BLINK
);

    localparam int PW = $clog2(TICK_DIV);

    logic [PW-1:0] presc;
    logic          tick;
    logic          modeRise;
    logic          adjRise;
    mode_t         modeState;
    mode_t         nextMode;
    pulse_t        nextPulse;
    pulse_t        pulseReg;
    logic          blinkReg;
    logic          s9, s59, m9, m59, h23;

    key_edge uModeEdge (.CP(CP), .CR(CR), .key(KEY_MODE), .rise(modeRise));
    key_edge uAdjEdge  (.CP(CP), .CR(CR), .key(KEY_ADJ),  .rise(adjRise));

    assign tick = (presc == PW'(TICK_DIV - 1));

    always_ff @(posedge CP) begin
        if (CR) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Non-BCD digits never equal the limits, so they cannot produce a carry
    assign s9  = (SL == UNITS_MAX);
    assign s59 = s9 & (SH == TENS_MAX);
    assign m9  = (ML == UNITS_MAX);
    assign m59 = m9 & (MH == TENS_MAX);
    assign h23 = (HH == HOUR_TENS_MAX) & (HL == HOUR_UNITS_MAX);

    always_comb begin
        nextPulse = '0;
        nextMode  = modeState;
        case (modeState)
            RUN: begin
                if (modeRise) begin
                    nextMode       = SET_HR;
                    nextPulse.clrS = 1'b1;
                end
                if (tick) begin
                    nextPulse.enSl = 1'b1;
                    nextPulse.enSh = s9;
                    nextPulse.enMl = s59;
                    nextPulse.enMh = s59 & m9;
                    if (s59 & m59 & h23) begin
                        nextPulse.clrH = 1'b1;
                    end else if (s59 & m59) begin
                        nextPulse.enHl = 1'b1;
                        nextPulse.enHh = (HL == UNITS_MAX);
                    end
                end
            end
            SET_HR: begin
                if (modeRise) begin
                    nextMode = SET_MIN;
                end else if (adjRise) begin
                    if (h23) begin
                        nextPulse.clrH = 1'b1;
                    end else begin
                        nextPulse.enHl = 1'b1;
                        nextPulse.enHh = (HL == UNITS_MAX);
                    end
                end
            end
            SET_MIN: begin
                if (modeRise) begin
                    nextMode = RUN;
                end else if (adjRise) begin
                    nextPulse.enMl = 1'b1;
                    nextPulse.enMh = m9;
                end
            end
            default: nextMode = RUN;
        endcase
    end

    always_ff @(posedge CP) begin
        if (CR) begin
            modeState <= RUN;
            pulseReg  <= '0;
            blinkReg  <= 1'b0;
        end else begin
            modeState <= nextMode;
            pulseReg  <= nextPulse;
            blinkReg  <= (modeState != RUN) && (presc < PW'(TICK_DIV / 2));
        end
    end

    assign MODE  = modeState;
    assign BLINK = blinkReg;
    assign EN_SL = pulseReg.enSl;
    assign EN_SH = pulseReg.enSh;
    assign EN_ML = pulseReg.enMl;
    assign EN_MH = pulseReg.enMh;
    assign EN_HL = pulseReg.enHl;
    assign EN_HH = pulseReg.enHh;
    assign CLR_H = pulseReg.clrH;
    assign CLR_S = pulseReg.clrS;

endmodule

// File: tb/tb_clock_ctrl.sv
// tb/tb_clock_ctrl.sv - directed self-checking bench for clock_ctrl with TICK_DIV=4
module tb_clock_ctrl;

    logic       CP = 1'b0;
    logic       CR = 1'b0;
    logic       KEY_MODE = 1'b0;
    logic       KEY_ADJ = 1'b0;
    logic [3:0] SL = '0, SH = '0, ML = '0, MH = '0, HL = '0, HH = '0;
    logic       EN_SL, EN_SH, EN_ML, EN_MH, EN_HL, EN_HH, CLR_H, CLR_S;
    logic [1:0] MODE;
    logic       BLINK;
    logic [7:0] outs;

    int errors = 0;
    int checks = 0;
    int phase  = 0;

    clock_ctrl #(.TICK_DIV(4)) dut (
        .CP(CP), .CR(CR), .KEY_MODE(KEY_MODE), .KEY_ADJ(KEY_ADJ),
        .SL(SL), .SH(SH), .ML(ML), .MH(MH), .HL(HL), .HH(HH),
        .EN_SL(EN_SL), .EN_SH(EN_SH), .EN_ML(EN_ML), .EN_MH(EN_MH),
        .EN_HL(EN_HL), .EN_HH(EN_HH), .CLR_H(CLR_H), .CLR_S(CLR_S),
        .MODE(MODE), .BLINK(BLINK)
    );

    always #5 CP = ~CP;

    // {EN_SL, EN_SH, EN_ML, EN_MH, EN_HL, EN_HH, CLR_H, CLR_S}
    assign outs = {EN_SL, EN_SH, EN_ML, EN_MH, EN_HL, EN_HH, CLR_H, CLR_S};

    // phase mirrors the prescaler value of the cycle we are now in
    task automatic cyc();
        logic r;
        r = CR;
        @(posedge CP);
        #1;
        phase = r ? 0 : (phase + 1) % 4;
    endtask

    task automatic wait_phase0();
        do cyc(); while (phase != 0);
    endtask

    task automatic set_digits(input logic [3:0] hh, hl, mh, ml, sh, sl);
        HH = hh; HL = hl; MH = mh; ML = ml; SH = sh; SL = sl;
    endtask

    task automatic test_reset();
        KEY_MODE = 1'b1;
        CR = 1'b1;
        cyc();
        cyc();
        CR = 1'b0;
        checks++;
        if (outs !== 8'b0 || MODE !== 2'd0 || BLINK !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: outs=%b MODE=%0d BLINK=%b expected outs=00000000 MODE=0 BLINK=0", outs, MODE, BLINK);
        end
        for (int n = 1; n <= 8; n++) begin
            cyc();
            checks++;
            if (outs !== {(phase == 0), 7'b0} || MODE !== 2'd0) begin
                errors++;
                $display("FAIL reset_tick n=%0d: outs=%b MODE=%0d expected outs=%b MODE=0", n, outs, MODE, {(phase == 0), 7'b0});
            end
        end
        KEY_MODE = 1'b0;
        cyc();
    endtask

    task automatic test_run_carry();
        logic [3:0] d [5][6];
        logic [7:0] exp [5];
        d[0] = '{4'd2, 4'd3, 4'd5, 4'd9, 4'd5, 4'd9}; exp[0] = 8'b1111_0010;
        d[1] = '{4'd0, 4'd9, 4'd5, 4'd9, 4'd5, 4'd9}; exp[1] = 8'b1111_1100;
        d[2] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd4, 4'd9}; exp[2] = 8'b1100_0000;
        d[3] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd9}; exp[3] = 8'b1110_0000;
        d[4] = '{4'd1, 4'd4, 4'd5, 4'd9, 4'd5, 4'd9}; exp[4] = 8'b1111_1000;
        for (int i = 0; i < 5; i++) begin
            set_digits(d[i][0], d[i][1], d[i][2], d[i][3], d[i][4], d[i][5]);
            wait_phase0();
            checks++;
            if (outs !== exp[i]) begin
                errors++;
                $display("FAIL run_tick vec%0d: outs=%b expected %b", i, outs, exp[i]);
            end
            cyc();
            checks++;
            if (outs !== 8'b0) begin
                errors++;
                $display("FAIL run_one_cycle vec%0d: outs=%b expected 00000000", i, outs);
            end
        end
    endtask

    task automatic test_set_hour();
        wait_phase0();
        KEY_MODE = 1'b1;
        cyc();
        checks++;
        if (MODE !== 2'd1 || outs !== 8'b0000_0001) begin
            errors++;
            $display("FAIL enter_set_hr: MODE=%0d outs=%b expected MODE=1 outs=00000001", MODE, outs);
        end
        KEY_MODE = 1'b0;
        cyc();
        checks++;
        if (outs !== 8'b0) begin
            errors++;
            $display("FAIL clr_s_once: outs=%b expected 00000000", outs);
        end
        set_digits(4'd2, 4'd3, 4'd5, 4'd9, 4'd5, 4'd9);
        KEY_ADJ = 1'b1;
        cyc();
        checks++;
        if (outs !== 8'b0000_0010) begin
            errors++;
            $display("FAIL adj_hr_23: outs=%b expected 00000010", outs);
        end
        KEY_ADJ = 1'b0;
        HH = 4'd1; HL = 4'd9;
        cyc();
        KEY_ADJ = 1'b1;
        cyc();
        checks++;
        if (outs !== 8'b0000_1100) begin
            errors++;
            $display("FAIL adj_hr_19: outs=%b expected 00001100", outs);
        end
        KEY_ADJ = 1'b0;
        set_digits(4'd2, 4'd3, 4'd5, 4'd9, 4'd5, 4'd9);
        for (int n = 0; n < 8; n++) begin
            cyc();
            checks++;
            if (outs !== 8'b0 || MODE !== 2'd1) begin
                errors++;
                $display("FAIL set_hr_frozen n=%0d: outs=%b MODE=%0d expected outs=00000000 MODE=1", n, outs, MODE);
            end
        end
    endtask

    task automatic test_blink();
        for (int n = 0; n < 8; n++) begin
            cyc();
            checks++;
            if (BLINK !== (phase == 1 || phase == 2)) begin
                errors++;
                $display("FAIL blink_set_hr n=%0d: BLINK=%b expected %b", n, BLINK, (phase == 1 || phase == 2));
            end
        end
    endtask

    task automatic test_set_min();
        KEY_MODE = 1'b1;
        cyc();
        checks++;
        if (MODE !== 2'd2 || outs !== 8'b0) begin
            errors++;
            $display("FAIL enter_set_min: MODE=%0d outs=%b expected MODE=2 outs=00000000", MODE, outs);
        end
        KEY_MODE = 1'b0;
        set_digits(4'd1, 4'd9, 4'd5, 4'd9, 4'd0, 4'd0);
        cyc();
        KEY_ADJ = 1'b1;
        cyc();
        checks++;
        if (outs !== 8'b0011_0000) begin
            errors++;
            $display("FAIL adj_min_59: outs=%b expected 00110000", outs);
        end
        KEY_ADJ = 1'b0;
        ML = 4'd3;
        cyc();
        KEY_ADJ = 1'b1;
        cyc();
        checks++;
        if (outs !== 8'b0010_0000) begin
            errors++;
            $display("FAIL adj_min_53: outs=%b expected 00100000", outs);
        end
        KEY_ADJ = 1'b0;
        ML = 4'd9;
        cyc();
        KEY_MODE = 1'b1;
        KEY_ADJ  = 1'b1;
        cyc();
        checks++;
        if (MODE !== 2'd0 || outs !== 8'b0) begin
            errors++;
            $display("FAIL mode_beats_adj: MODE=%0d outs=%b expected MODE=0 outs=00000000", MODE, outs);
        end
        KEY_MODE = 1'b0;
        KEY_ADJ  = 1'b0;
        cyc();
        for (int n = 0; n < 4; n++) begin
            cyc();
            checks++;
            if (BLINK !== 1'b0 || MODE !== 2'd0) begin
                errors++;
                $display("FAIL blink_run n=%0d: BLINK=%b MODE=%0d expected BLINK=0 MODE=0", n, BLINK, MODE);
            end
        end
    endtask

    task automatic test_reset_mid();
        wait_phase0();
        KEY_MODE = 1'b1;
        cyc();
        KEY_MODE = 1'b0;
        cyc();
        checks++;
        if (MODE !== 2'd1) begin
            errors++;
            $display("FAIL mid_enter_set_hr: MODE=%0d expected 1", MODE);
        end
        set_digits(4'd0, 4'd5, 4'd0, 4'd0, 4'd0, 4'd0);
        KEY_ADJ = 1'b1;
        CR = 1'b1;
        cyc();
        CR = 1'b0;
        checks++;
        if (outs !== 8'b0 || MODE !== 2'd0) begin
            errors++;
            $display("FAIL mid_reset_drop: outs=%b MODE=%0d expected outs=00000000 MODE=0", outs, MODE);
        end
        for (int n = 0; n < 3; n++) begin
            cyc();
            checks++;
            if (outs !== 8'b0 || MODE !== 2'd0) begin
                errors++;
                $display("FAIL mid_reset_after n=%0d: outs=%b MODE=%0d expected outs=00000000 MODE=0", n, outs, MODE);
            end
        end
        KEY_ADJ = 1'b0;
        cyc();
    endtask

    initial begin
        test_reset();
        test_run_carry();
        test_set_hour();
        test_blink();
        test_set_min();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
